// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding, default width and counter sizing for seq_div
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int DIV_WIDTH_DEFAULT = 32;
  function automatic int clog2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << i) < w) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/seq_div_step.sv
// div_step: one restoring-division iteration using a carry-chain trial subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:1] quo_o,
  output logic             ok_o
);
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] sum;
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign sum   = {1'b0, sh} + {1'b0, ~{1'b0, div_i}} + (WIDTH+2)'(1);
  assign ok_o  = sum[WIDTH+1];
  assign rem_o = WIDTH'(ok_o ? sum : {1'b0, sh});
  assign quo_o = quo_i[WIDTH-2:0];
endmodule

// File: rtl/seq_div.sv
// seq_div: iterative restoring divider with valid/ready handshakes; SEQ_DIV_SIGNED_EN adds signed mode
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_Dividend,
  input  logic [WIDTH-1:0] i_Divisor,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [WIDTH-1:0] o_Remainder,
  output logic             o_DivZero
`ifdef SEQ_DIV_SIGNED_EN
  ,
  input  logic             i_Signed
`endif
);
  localparam int CW = clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic             dz_q, dz_d, nq_q, nq_d, nr_q, nr_d;
  logic             sgn, step_ok;
  logic [WIDTH-1:0] mag_a, mag_b, step_rem;
  logic [WIDTH-1:1] step_quo;
`ifdef SEQ_DIV_SIGNED_EN
  assign sgn = i_Signed;
`else
  assign sgn = 1'b0;
`endif
  assign mag_a       = sgn & i_Dividend[WIDTH-1] ? -i_Dividend : i_Dividend;
  assign mag_b       = sgn & i_Divisor[WIDTH-1] ? -i_Divisor : i_Divisor;
  assign o_Ready     = state_q == IDLE;
  assign o_Valid     = state_q == DONE;
  assign o_Quotient  = q_out_q;
  assign o_Remainder = r_out_q;
  assign o_DivZero   = dz_q;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(step_rem),
    .quo_o(step_quo),
    .ok_o (step_ok)
  );
  // next state: latch operands on accept, iterate in CALC, apply sign fix-up on DONE entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    case (state_q)
      IDLE: if (i_Valid) begin
        dz_d = i_Divisor == '0;
        if (dz_d) begin
          state_d = DONE;
          q_out_d = '1;
          r_out_d = i_Dividend;
        end else begin
          state_d = CALC;
          rem_d   = '0;
          quo_d   = mag_a;
          div_d   = mag_b;
          cnt_d   = CW'(WIDTH - 1);
          nq_d    = sgn & (i_Dividend[WIDTH-1] ^ i_Divisor[WIDTH-1]);
          nr_d    = sgn & i_Dividend[WIDTH-1];
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {step_quo, step_ok};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          q_out_d = nq_q ? -quo_d : quo_d;
          r_out_d = nr_q ? -rem_d : rem_d;
        end
      end
      DONE: state_d = i_Ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized and directed checks of seq_div against an arithmetic reference model
module tb_seq_div;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, sgn = 0;
  logic [W-1:0] dvd = '0, dvs = '0;
  logic o_ready, o_valid, o_dz;
  logic [W-1:0] o_quo, o_rem;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  seq_div #(.WIDTH(W)) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Valid(in_valid),
    .o_Ready(o_ready),
    .i_Dividend(dvd),
    .i_Divisor(dvs),
    .o_Valid(o_valid),
    .i_Ready(out_ready),
    .o_Quotient(o_quo),
    .o_Remainder(o_rem),
    .o_DivZero(o_dz)
`ifdef SEQ_DIV_SIGNED_EN
    ,
    .i_Signed(sgn)
`endif
  );
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, b, input logic s);
    longint sa, sb;
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    if (!s) return {a / b, a % b, 1'b0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return {W'(sa / sb), W'(sa % sb), 1'b0};
  endfunction
  task automatic run_op(input logic [W-1:0] a, b, input logic s,
                        output logic [2*W:0] res, output int lat);
    @(negedge clk);
    dvd = a;
    dvs = b;
    sgn = s;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = {o_quo, o_rem, o_dz};
  endtask
  task automatic release_op;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ready, o_valid, o_quo, o_rem, o_dz} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0})
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b want rdy=1 vld=0 q=0 r=0 dz=0",
               o_ready, o_valid, o_quo, o_rem, o_dz);
    else passes++;
    rst_n = 1;
  endtask
  task automatic test_directed;
    logic [W-1:0] ta [5] = '{32'd100, 32'h1234, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [W-1:0] tb [5] = '{32'd7, 32'd0, 32'd1, 32'd9, 32'hFFFF_FFFF};
    logic [2*W:0] res, exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b0, res, lat);
      exp = ref_div(ta[i], tb[i], 1'b0);
      checks++;
      if (res !== exp) $display("FAIL directed[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                i, ta[i], tb[i], res[2*W:W+1], res[W:1], res[0], exp[2*W:W+1], exp[W:1], exp[0]);
      else passes++;
      checks++;
      if (lat != (tb[i] == '0 ? 1 : W + 1)) $display("FAIL directed_latency[%0d]: got %0d want %0d",
                                                   i, lat, tb[i] == '0 ? 1 : W + 1);
      else passes++;
      release_op();
    end
  endtask
  task automatic test_signed;
    logic [W-1:0] ta [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [W-1:0] tb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    logic [2*W:0] res, exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b1, res, lat);
      exp = ref_div(ta[i], tb[i], 1'b1);
      checks++;
      if (res !== exp) $display("FAIL signed[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                i, ta[i], tb[i], res[2*W:W+1], res[W:1], res[0], exp[2*W:W+1], exp[W:1], exp[0]);
      else passes++;
      release_op();
    end
  endtask
  task automatic test_random;
    logic [W-1:0] a, b;
    logic s;
    logic [2*W:0] res, exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 16);
        2: b = a >> $urandom_range(0, 31);
        3: b = '0;
        default: b = a + W'($urandom_range(0, 3));
      endcase
`ifdef SEQ_DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(a, b, s, res, lat);
      exp = ref_div(a, b, s);
      checks++;
      if (res !== exp) $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                i, a, b, s, res[2*W:W+1], res[W:1], res[0], exp[2*W:W+1], exp[W:1], exp[0]);
      else passes++;
      checks++;
      if (lat != (b == '0 ? 1 : W + 1)) $display("FAIL random_latency[%0d]: got %0d want %0d",
                                               i, lat, b == '0 ? 1 : W + 1);
      else passes++;
      release_op();
    end
  endtask
  task automatic test_back_to_back;
    logic [2*W:0] res;
    int lat;
    run_op(32'd1000, 32'd3, 1'b0, res, lat);
    dvd = 32'd77;
    dvs = 32'd7;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({o_ready, o_valid, o_quo, o_rem} !== {1'b0, 1'b1, 32'd333, 32'd1})
        $display("FAIL backpressure[%0d]: rdy=%b vld=%b q=%h r=%h want rdy=0 vld=1 q=14d r=1",
                 i, o_ready, o_valid, o_quo, o_rem);
      else passes++;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    in_valid = 0;
    checks++;
    if ({o_ready, o_valid, o_quo, o_rem} !== {1'b1, 1'b0, 32'd333, 32'd1})
      $display("FAIL handshake_release: rdy=%b vld=%b q=%h r=%h want rdy=1 vld=0 q=14d r=1",
               o_ready, o_valid, o_quo, o_rem);
    else passes++;
    run_op(32'd77, 32'd7, 1'b0, res, lat);
    checks++;
    if (res !== {32'd11, 32'd0, 1'b0}) $display("FAIL follow_on: got q=%h r=%h dz=%b want q=b r=0 dz=0",
                                               res[2*W:W+1], res[W:1], res[0]);
    else passes++;
    release_op();
  endtask
  task automatic test_reset_mid;
    logic [2*W:0] res;
    int lat;
    @(negedge clk);
    dvd = 32'd1000;
    dvs = 32'd3;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ready, o_quo} !== {1'b0, 1'b1, {W{1'b0}}})
      $display("FAIL reset_mid: vld=%b rdy=%b q=%h want vld=0 rdy=1 q=0", o_valid, o_ready, o_quo);
    else passes++;
    rst_n = 1;
    run_op(32'd50, 32'd5, 1'b0, res, lat);
    checks++;
    if (res !== {32'd10, 32'd0, 1'b0} || lat != W + 1)
      $display("FAIL after_reset 50/5: got q=%h r=%h dz=%b lat=%0d want q=a r=0 dz=0 lat=%0d",
               res[2*W:W+1], res[W:1], res[0], lat, W + 1);
    else passes++;
    release_op();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_directed();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
